add32_seq: RTL and testbench
============================

ADD32_SEQ -- requirements
Module: add32_seq

Interface
REQ-001 SHALL have parameter: NBYTES, 4, number of 8-bit slices processed per operation (operand width = 8*NBYTES).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request new operation; sampled only when not busy.
REQ-005 SHALL have port: op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port: a  input  8*NBYTES  operand A; sampled with start.
REQ-007 SHALL have port: b  input  8*NBYTES  operand B; sampled with start.
REQ-008 SHALL have port: busy  output  1  operation in progress.
REQ-009 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port: result  output  8*NBYTES  sum/difference; held until next accepted start.
REQ-011 SHALL have port: cout  output  1  carry out of MSB slice (subtract: 1 = no borrow).
REQ-012 SHALL have port: overflow  output  1  signed two's-complement overflow.
REQ-013 SHALL have port: zero  output  1  result equals 0.

Function
REQ-014 SHALL use exactly one 8-bit adder slice, time-multiplexed, one byte per clock, LSB byte first.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after byte NBYTES-1; DONE->IDLE next cycle unless start, DONE->RUN on start.
REQ-016 SHALL on accepted start latch a, b (b bit-inverted if op_sub), set carry register = op_sub, byte index = 0.
REQ-017 SHALL in RUN feed slice a_byte[idx], b_byte[idx], carry register; write slice sum into result byte idx, carry-out into carry register, increment idx.
REQ-018 SHALL assert done for exactly one cycle, NBYTES cycles after the edge sampling start; result/flags valid when done is high.
REQ-019 SHALL hold busy high in RUN only; start while busy ignored, latched operands unaffected.
REQ-020 SHALL accept start in the DONE cycle (back-to-back, no idle gap).
REQ-021 SHALL compute overflow = carry into MSB bit XOR carry out of MSB bit of final slice; cout = final carry register.
REQ-022 SHALL compute zero from the complete registered result, valid with done.
REQ-023 SHALL leave result/flags from the previous operation unchanged until the first RUN byte write of the next.
REQ-024 SHALL wrap modulo 2^(8*NBYTES) with no saturation.

Reset
REQ-025 SHALL on rst asynchronously force state IDLE, idx 0, carry 0, busy 0, done 0, result 0, cout 0, overflow 0, zero 0.
REQ-026 SHALL abort any in-progress operation on rst mid-RUN; no done pulse for the aborted operation.
REQ-027 SHALL not accept start in the cycle rst is high.

Structure
REQ-028 SHALL place FSM state encodings and slice width (8) in the shared ALU constants header.
REQ-029 SHALL instantiate existing sub-module adder8 (ports a, b, cin, sum, cout) as the single slice; no other adder logic.

Verification
REQ-030 SHALL test a=0x000000FF, b=0x00000001, add -> result 0x00000100, cout 0, overflow 0, zero 0, done exactly 4 cycles after start.
REQ-031 SHALL test a=0xFFFFFFFF, b=0x00000001, add -> result 0x00000000, cout 1, zero 1, overflow 0.
REQ-032 SHALL test a=0x00000005, b=0x00000007, sub -> result 0xFFFFFFFE, cout 0, overflow 0; then a=0x7FFFFFFF, b=0x00000001, add -> 0x80000000, overflow 1.
REQ-033 SHALL test start pulsed again 2 cycles into RUN with different operands -> ignored, first result unchanged, single done.
REQ-034 SHALL test back-to-back: start held during DONE cycle -> second operation runs, done again 4 cycles later, correct result.
REQ-035 SHALL test rst asserted during byte 2 -> all outputs 0 immediately, no done; next start completes normally.

Source files
------------

// File: rtl/add32_seq_pkg.sv
// Shared ALU constants: adder slice width and the sequencer state encoding.
package add32_seq_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder8.sv
// Single 8-bit ripple adder slice with carry in/out.
module adder8
  import add32_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (SLICE_W + 1)'(cin);

endmodule

// File: rtl/add32_seq.sv
// Byte-serial add/subtract: one adder8 slice reused LSB byte first,
// NBYTES cycles per operation, flags captured on the final byte.
module add32_seq
  import add32_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [SLICE_W*NBYTES-1:0] a,
  input  logic [SLICE_W*NBYTES-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [SLICE_W*NBYTES-1:0] result,
  output logic                      cout,
  output logic                      overflow,
  output logic                      zero
);

  localparam int unsigned W     = SLICE_W * NBYTES;
  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, b_q, result_q, result_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q, cout_q, ovf_q, zero_q;
  logic [SLICE_W-1:0] s_a, s_b, s_sum;
  logic               s_cout;
  logic               accept, last;

  // start is honoured whenever no operation is in flight (IDLE or DONE)
  assign accept = start && (state_q != RUN);
  assign last   = (idx_q == IDX_W'(NBYTES - 1));

  assign s_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign s_b = b_q[idx_q*SLICE_W +: SLICE_W];

  adder8 u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: DONE lasts one cycle unless a new start chains straight into RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Result with the current byte replaced by the slice sum
  always_comb begin
    result_d = result_q;
    result_d[idx_q*SLICE_W +: SLICE_W] = s_sum;
  end

  // Operand latch on accept; byte write-back, carry chain and final flags in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      // subtract as a + ~b + 1: inverted operand, carry seeded with 1
      a_q     <= a;
      b_q     <= op_sub ? ~b : b;
      carry_q <= op_sub;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      result_q <= result_d;
      carry_q  <= s_cout;
      idx_q    <= idx_q + 1'b1;
      if (last) begin
        cout_q <= s_cout;
        ovf_q  <= (s_a[SLICE_W-1] ^ s_b[SLICE_W-1] ^ s_sum[SLICE_W-1]) ^ s_cout;
        zero_q <= (result_d == '0);
      end
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_add32_seq.sv
// Scoreboard bench for add32_seq: expected results queued at start, checked on done.
module tb_add32_seq;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk, rst, start, op_sub;
  logic [W-1:0] a_s, b_s;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  add32_seq #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a_s),
    .b        (b_s),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, input int unsigned c);
    exp_t        e;
    logic [W:0]  full;
    if (sub) full = {1'b0, x} + {1'b0, ~y} + (W + 1)'(1);
    else     full = {1'b0, x} + {1'b0, y};
    e.res = full[W-1:0];
    e.co  = full[W];
    if (sub) e.ov = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    else     e.ov = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    e.z   = (e.res == '0);
    e.cyc = c;
    return e;
  endfunction

  // Called at a negedge; the next posedge samples start.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sub, input bit push);
    start  = 1'b1;
    a_s    = x;
    b_s    = y;
    op_sub = sub;
    if (push) sb.push_back(model(x, y, sub, cyc + 1));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", W'(sb.size()), '0);
      sb.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", W'(done), W'(1));
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    @(negedge clk);
    drive(x, y, sub, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);
  endtask

  // Compare every completion against the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", W'(done), '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",   result,          e.res);
        chk("cout",     W'(cout),        W'(e.co));
        chk("overflow", W'(overflow),    W'(e.ov));
        chk("zero",     W'(zero),        W'(e.z));
        chk("latency",  W'(cyc - e.cyc), W'(NBYTES));
        chk("busy_in_done", W'(busy),    '0);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b1;
    op_sub = 1'b0;
    a_s    = 32'h1234_5678;
    b_s    = 32'h1111_1111;

    // reset state, with start held high during reset
    repeat (2) @(negedge clk);
    chk("rst_busy",     W'(busy),     '0);
    chk("rst_done",     W'(done),     '0);
    chk("rst_result",   result,       '0);
    chk("rst_cout",     W'(cout),     '0);
    chk("rst_overflow", W'(overflow), '0);
    chk("rst_zero",     W'(zero),     '0);
    start = 1'b0;
    rst   = 1'b0;

    // directed arithmetic cases
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1);

    // start during RUN is ignored
    @(negedge clk);
    drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_run", W'(busy), W'(1));
    drive(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);
    repeat (3) @(negedge clk);
    chk("hold_result", result, 32'h2345_6789);
    chk("idle_busy",   W'(busy), '0);

    // back-to-back: start asserted in the DONE cycle
    @(negedge clk);
    drive(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    drive(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", W'(busy), W'(1));
    wait_drain(20);

    // random operations
    for (int i = 0; i < 8; i++) run_op($urandom, $urandom, 1'($urandom_range(0, 1)));

    // reset while byte 2 is in progress
    @(negedge clk);
    drive(32'h89AB_CDEF, 32'h7654_3210, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_result",   result,       '0);
    chk("abort_busy",     W'(busy),     '0);
    chk("abort_done",     W'(done),     '0);
    chk("abort_cout",     W'(cout),     '0);
    chk("abort_overflow", W'(overflow), '0);
    chk("abort_zero",     W'(zero),     '0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_abort_done", W'(done), '0);
    chk("post_abort_busy", W'(busy), '0);
    run_op(32'h0000_1000, 32'h0000_0FFF, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
